// File: rtl/ascii_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : ascii_uart_rx
// Purpose  : 8N1 serial receiver; delivers ASCII bytes on a valid/ready port,
//            flags framing errors and overruns instead of passing them on.
// Revision : 1.0 - initial release
// ============================================================================
module ascii_uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] ascii_out,
    output logic       ascii_valid,
    input  logic       ascii_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
    localparam logic [2:0] c_STOP      = 3'd3;
    localparam logic [2:0] c_WAIT_HIGH = 3'd4;

    logic               r_sync1;
    logic               r_sync2;
    logic               w_rx_s;
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic               w_cnt_clr;
    logic               w_idx_clr;
    logic               w_shift_en;
    logic               w_byte_good;
    logic               w_frame_bad;
    logic               w_load;
    logic [7:0]         r_ascii_out;
    logic               r_valid;
    logic               r_frame_err;
    logic               r_overrun;

    assign w_rx_s = r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_serial;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // START samples at mid-bit; DATA/STOP then sample a full bit period later.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_idx_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_byte_good = 1'b0;
        w_frame_bad = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_cnt_clr = 1'b1;
                if (!w_rx_s) begin
                    w_state_nxt = c_START;
                end
            end
            c_START: begin
                if (r_cnt == c_HALF_M1) begin
                    w_cnt_clr   = 1'b1;
                    w_idx_clr   = 1'b1;
                    w_state_nxt = w_rx_s ? c_IDLE : c_DATA;
                end
            end
            c_DATA: begin
                if (r_cnt == c_FULL_M1) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = c_STOP;
                    end
                end
            end
            c_STOP: begin
                if (r_cnt == c_FULL_M1) begin
                    w_cnt_clr = 1'b1;
                    if (w_rx_s) begin
                        w_byte_good = 1'b1;
                        w_state_nxt = c_IDLE;
                    end else begin
                        w_frame_bad = 1'b1;
                        w_state_nxt = c_WAIT_HIGH;
                    end
                end
            end
            c_WAIT_HIGH: begin
                w_cnt_clr = 1'b1;
                if (w_rx_s) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_idx_clr) begin
                r_idx <= 3'd0;
            end else if (w_shift_en) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_shift_en) begin
                r_shift <= {w_rx_s, r_shift[7:1]};
            end
        end
    end

    // A byte may replace the held one only if it is being accepted this cycle.
    assign w_load = w_byte_good && (!r_valid || ascii_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ascii_out <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_bad;
            r_overrun   <= w_byte_good && r_valid && !ascii_ready;
            if (w_load) begin
                r_ascii_out <= r_shift;
                r_valid     <= 1'b1;
            end else if (r_valid && ascii_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign ascii_out   = r_ascii_out;
    assign ascii_valid = r_valid;
    assign frame_err   = r_frame_err;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_ascii_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascii_uart_rx
// Purpose  : Directed frames against a completion-time model of the receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ascii_uart_rx;

    localparam int c_CLKS     = 16;
    // Edges from the first edge that sees the line low to the result edge.
    localparam int c_DONE_OFS = c_CLKS / 2 + 9 * c_CLKS + 2;

    typedef struct {
        int unsigned at;
        logic        is_err;
        logic [7:0]  data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_serial;
    logic [7:0] ascii_out;
    logic       ascii_valid;
    logic       ascii_ready;
    logic       frame_err;
    logic       overrun;

    ev_t         exp_q[$];
    int unsigned e = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned vhi_cnt = 0;
    int unsigned vrise_cnt = 0;
    int unsigned ferr_cnt = 0;
    int unsigned ovr_cnt = 0;
    int unsigned rise_e = 0;
    int unsigned last_f = 0;

    logic [7:0] m_out = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_ovr = 1'b0;

    always #5 clk = ~clk;

    ascii_uart_rx #(.CLKS_PER_BIT(c_CLKS)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_serial   (rx_serial),
        .ascii_out   (ascii_out),
        .ascii_valid (ascii_valid),
        .ascii_ready (ascii_ready),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    function automatic logic [7:0] to_upper(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives a full frame and predicts when it resolves.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int extra_low);
        ev_t ev;
        last_f    = e + 1;
        ev.at     = last_f + c_DONE_OFS;
        ev.is_err = !stop_bit;
        ev.data   = data;
        exp_q.push_back(ev);
        rx_serial = 1'b0;
        repeat (c_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_serial = data[i];
            repeat (c_CLKS) @(negedge clk);
        end
        rx_serial = stop_bit;
        repeat (c_CLKS + extra_low) @(negedge clk);
        rx_serial = 1'b1;
    endtask

    initial begin : monitor
        logic s_rst;
        logic s_rdy;
        logic good;
        logic prev_valid;
        ev_t  ev;
        prev_valid = 1'b0;
        ev = '{at: 0, is_err: 1'b0, data: 8'h00};
        forever begin
            @(posedge clk);
            s_rst = rst;
            s_rdy = ascii_ready;
            #1;
            e = e + 1;
            if (s_rst) begin
                m_out = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
                exp_q.delete();
            end else begin
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
                good   = 1'b0;
                if (exp_q.size() > 0 && exp_q[0].at == e) begin
                    ev = exp_q.pop_front();
                    if (ev.is_err) m_ferr = 1'b1;
                    else           good   = 1'b1;
                end
                if (good && (!m_valid || s_rdy)) begin
                    m_out   = ev.data;
                    m_valid = 1'b1;
                end else if (good) begin
                    m_ovr = 1'b1;
                end else if (m_valid && s_rdy) begin
                    m_valid = 1'b0;
                end
            end
            vectors = vectors + 1;
            if (ascii_out !== m_out || ascii_valid !== m_valid ||
                frame_err !== m_ferr || overrun !== m_ovr) begin
                miscompares = miscompares + 1;
                $display("FAIL cycle %0d outputs: got out=%h valid=%b ferr=%b ovr=%b, expected out=%h valid=%b ferr=%b ovr=%b",
                         e, ascii_out, ascii_valid, frame_err, overrun, m_out, m_valid, m_ferr, m_ovr);
            end
            if (ascii_valid === 1'b1) vhi_cnt = vhi_cnt + 1;
            if (ascii_valid === 1'b1 && prev_valid !== 1'b1) begin
                vrise_cnt = vrise_cnt + 1;
                rise_e    = e;
            end
            prev_valid = ascii_valid;
            if (frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
            if (overrun === 1'b1)   ovr_cnt  = ovr_cnt + 1;
        end
    end

    initial begin : stimulus
        int unsigned h0, f0, o0, r0, t_load;
        logic [7:0]  b7f;
        rst = 1'b1; rx_serial = 1'b1; ascii_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_state", {21'h0, ascii_out, ascii_valid, frame_err, overrun}, 32'h0);

        // 'a' with the consumer always ready
        ascii_ready = 1'b1;
        repeat (4) @(negedge clk);
        h0 = vhi_cnt;
        send_frame(8'h61, 1'b1, 0);
        repeat (c_CLKS) @(negedge clk);
        check("a_rise_cycle", rise_e - (last_f + 1), 153);
        check("a_valid_cycles", vhi_cnt - h0, 1);
        check("a_byte", {24'h0, ascii_out}, 8'h61);
        check("a_to_upper", {24'h0, to_upper(ascii_out)}, 8'h41);

        // short low glitch, then 'z'
        h0 = vhi_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        rx_serial = 1'b0;
        repeat (4) @(negedge clk);
        rx_serial = 1'b1;
        repeat (2 * c_CLKS) @(negedge clk);
        check("glitch_quiet", (vhi_cnt - h0) + (ferr_cnt - f0) + (ovr_cnt - o0), 0);
        send_frame(8'h7A, 1'b1, 0);
        repeat (c_CLKS) @(negedge clk);
        check("z_byte", {24'h0, ascii_out}, 8'h7A);
        check("z_valid_cycles", vhi_cnt - h0, 1);

        // framing error with line held low, then 'H'
        h0 = vhi_cnt; f0 = ferr_cnt;
        send_frame(8'h41, 1'b0, 40);
        repeat (2 * c_CLKS) @(negedge clk);
        check("ferr_pulses", ferr_cnt - f0, 1);
        check("ferr_no_valid", vhi_cnt - h0, 0);
        send_frame(8'h48, 1'b1, 0);
        repeat (c_CLKS) @(negedge clk);
        check("h_byte", {24'h0, ascii_out}, 8'h48);

        // overrun while the consumer stalls
        ascii_ready = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h6D, 1'b1, 0);
        repeat (c_CLKS) @(negedge clk);
        send_frame(8'h30, 1'b1, 0);
        repeat (c_CLKS) @(negedge clk);
        check("ovr_hold_byte", {24'h0, ascii_out}, 8'h6D);
        check("ovr_hold_valid", {31'h0, ascii_valid}, 1);
        check("ovr_pulses", ovr_cnt - o0, 1);
        ascii_ready = 1'b1;
        @(negedge clk);
        ascii_ready = 1'b0;
        @(negedge clk);
        check("ovr_drain_valid", {31'h0, ascii_valid}, 0);
        check("ovr_drain_byte", {24'h0, ascii_out}, 8'h6D);

        // back-to-back frames, accept exactly as the second byte loads
        o0 = ovr_cnt; r0 = vrise_cnt;
        t_load = e + 1 + 10 * c_CLKS + c_DONE_OFS;
        fork
            begin
                send_frame(8'h6D, 1'b1, 0);
                send_frame(8'h30, 1'b1, 0);
            end
            begin
                for (int k = 0; k < 30 * c_CLKS && e != t_load - 1; k++) @(negedge clk);
                check("b2b_ready_slot", e, t_load - 1);
                ascii_ready = 1'b1;
                @(negedge clk);
                ascii_ready = 1'b0;
            end
        join
        repeat (c_CLKS) @(negedge clk);
        check("b2b_no_overrun", ovr_cnt - o0, 0);
        check("b2b_byte", {24'h0, ascii_out}, 8'h30);
        check("b2b_single_rise", vrise_cnt - r0, 1);
        check("b2b_valid", {31'h0, ascii_valid}, 1);

        // reset during data bit 3 of 0x7F, frame abandoned
        b7f = 8'h7F;
        rx_serial = 1'b0;
        repeat (c_CLKS) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_serial = b7f[i];
            repeat (c_CLKS) @(negedge clk);
        end
        rx_serial = b7f[3];
        repeat (c_CLKS / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_outputs", {21'h0, ascii_out, ascii_valid, frame_err, overrun}, 32'h0);
        rx_serial = 1'b1;
        repeat (c_CLKS) @(negedge clk);
        ascii_ready = 1'b1;
        r0 = vrise_cnt;
        send_frame(8'h30, 1'b1, 0);
        repeat (c_CLKS) @(negedge clk);
        check("post_rst_byte", {24'h0, ascii_out}, 8'h30);
        check("post_rst_rise", vrise_cnt - r0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
